// File: rtl/nios_system_nios2_cpu_div_cell_if.sv
// Operand/result bundle between the E-stage issue logic and the divide cell.
// Handshake: start is accepted on a rising edge only while busy=0; done pulses one cycle with results valid.
interface nios_system_nios2_cpu_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_div_signed;
    logic             E_div_start;
    logic             M_kill;
    logic             M_div_cell_busy;
    logic             M_div_cell_done;
    logic [WIDTH-1:0] M_div_cell_quot;
    logic [WIDTH-1:0] M_div_cell_rem;
    logic [2:0]       dbg_state;

    modport master (
        output E_src1, E_src2, E_div_signed, E_div_start, M_kill,
        input  M_div_cell_busy, M_div_cell_done, M_div_cell_quot, M_div_cell_rem, dbg_state
    );

    modport slave (
        input  E_src1, E_src2, E_div_signed, E_div_start, M_kill,
        output M_div_cell_busy, M_div_cell_done, M_div_cell_quot, M_div_cell_rem, dbg_state
    );
endinterface

// File: rtl/nios_system_nios2_cpu_div_cell.sv
// Radix-2 restoring divider for div/divu, one quotient bit per clock, WIDTH+3 cycle latency.
// Define NIOS2_DIV_CELL_REM_EN to keep the remainder output path; otherwise M_div_cell_rem reads 0.
module nios_system_nios2_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
    nios_system_nios2_cpu_div_cell_if.slave div_if
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             accept;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] q_reg, r_reg, b_reg;
    logic             signed_reg, neg_q;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial;
`ifdef NIOS2_DIV_CELL_REM_EN
    logic             neg_r;
    logic [WIDTH-1:0] rem_reg;
`endif

    // Requests are taken in IDLE and DONE so back-to-back divides lose no cycle.
    assign accept = div_if.E_div_start && !div_if.M_kill &&
                    (state == S_IDLE || state == S_DONE);

    assign a_abs = (signed_reg && q_reg[WIDTH-1]) ? -q_reg : q_reg;
    assign b_abs = (signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    // Bit WIDTH set means borrow: the shifted remainder is smaller than the divisor.
    assign trial = {r_reg, q_reg[WIDTH-1]} - {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt              = state;
        div_if.M_div_cell_busy = 1'b0;
        div_if.M_div_cell_done = 1'b0;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_PREP;
            S_PREP:  begin
                state_nxt              = S_ITER;
                div_if.M_div_cell_busy = 1'b1;
            end
            S_ITER:  begin
                if (cnt == LAST_CNT) state_nxt = S_FIXUP;
                div_if.M_div_cell_busy = 1'b1;
            end
            S_FIXUP: begin
                state_nxt              = S_DONE;
                div_if.M_div_cell_busy = 1'b1;
            end
            S_DONE:  begin
                state_nxt              = accept ? S_PREP : S_IDLE;
                div_if.M_div_cell_done = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (div_if.M_kill && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            neg_q      <= 1'b0;
            quot_reg   <= '0;
`ifdef NIOS2_DIV_CELL_REM_EN
            neg_r      <= 1'b0;
            rem_reg    <= '0;
`endif
        end else begin
            if (accept) begin
                q_reg      <= div_if.E_src1;
                b_reg      <= div_if.E_src2;
                signed_reg <= div_if.E_div_signed;
            end
            unique case (state)
                S_PREP: begin
                    q_reg <= a_abs;
                    b_reg <= b_abs;
                    r_reg <= '0;
                    cnt   <= '0;
                    // Divide-by-zero keeps the all-ones quotient unsigned-looking.
                    neg_q <= signed_reg && (q_reg[WIDTH-1] ^ b_reg[WIDTH-1]) && (b_reg != '0);
`ifdef NIOS2_DIV_CELL_REM_EN
                    neg_r <= signed_reg && q_reg[WIDTH-1];
`endif
                end
                S_ITER: begin
                    cnt <= cnt + 6'd1;
                    if (!trial[WIDTH]) begin
                        r_reg <= trial[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIXUP: begin
                    if (!div_if.M_kill) begin
                        quot_reg <= neg_q ? -q_reg : q_reg;
`ifdef NIOS2_DIV_CELL_REM_EN
                        rem_reg  <= neg_r ? -r_reg : r_reg;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.M_div_cell_quot = quot_reg;
`ifdef NIOS2_DIV_CELL_REM_EN
    assign div_if.M_div_cell_rem  = rem_reg;
`else
    assign div_if.M_div_cell_rem  = '0;
`endif
    assign div_if.dbg_state = state;
endmodule

// File: tb/tb_nios_system_nios2_cpu_div_cell.sv
// Bench for the divide cell: directed corner cases plus random div/divu against an arithmetic model.
`timescale 1ns/1ps
module tb_nios_system_nios2_cpu_div_cell;
  localparam int W   = 32;
  localparam int LAT = W + 3;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nios_system_nios2_cpu_div_cell_if #(.WIDTH(W)) dif();
  nios_system_nios2_cpu_div_cell #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .div_if(dif)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [W-1:0]   last_quot = '0;
  logic [W-1:0]   last_rem  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // reference model: truncating division, remainder follows the dividend
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] q, r;
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
`ifndef NIOS2_DIV_CELL_REM_EN
    r = '0;
`endif
    return {q, r};
  endfunction

  // driver tasks: always entered on a negedge with busy=0
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dif.E_src1       = a;
    dif.E_src2       = b;
    dif.E_div_signed = s;
    dif.E_div_start  = 1'b1;
    exp_q.push_back(model(a, b, s));
    exp_cyc_q.push_back(cyc + LAT);
    @(negedge clk);
    dif.E_div_start = 1'b0;
  endtask

  task automatic start_untracked(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.E_src1       = a;
    dif.E_src2       = b;
    dif.E_div_signed = 1'b0;
    dif.E_div_start  = 1'b1;
    @(negedge clk);
    dif.E_div_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dif.M_div_cell_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dif.M_div_cell_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout at cycle %0d: got no done, expected done within 200 cycles", cyc);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    issue(a, b, s);
    wait_done();
    @(negedge clk);
  endtask

  // scoreboard monitor
  logic [2*W-1:0] mon_e;
  int             mon_c;
  always @(negedge clk) begin
    if (!reset && dif.M_div_cell_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected no pending operation", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("quot", 64'(dif.M_div_cell_quot), 64'(mon_e[2*W-1:W]));
        check("rem", 64'(dif.M_div_cell_rem), 64'(mon_e[W-1:0]));
        check("latency", 64'(cyc), 64'(mon_c));
        check("busy_low_in_done", 64'(dif.M_div_cell_busy), 64'd0);
        last_quot = mon_e[2*W-1:W];
        last_rem  = mon_e[W-1:0];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [W-1:0] ra, rb;
    dif.E_src1 = '0; dif.E_src2 = '0; dif.E_div_signed = 1'b0;
    dif.E_div_start = 1'b0; dif.M_kill = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(dif.M_div_cell_busy), 64'd0);
    check("reset_done", 64'(dif.M_div_cell_done), 64'd0);
    check("reset_quot", 64'(dif.M_div_cell_quot), 64'd0);
    check("reset_rem", 64'(dif.M_div_cell_rem), 64'd0);
    check("reset_state", 64'(dif.dbg_state), 64'd0);

    // divu 100/7 with busy window and single-cycle done
    c0 = cyc;
    issue(32'd100, 32'd7, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      check("busy_window", 64'(dif.M_div_cell_busy), 64'd1);
      check("no_early_done", 64'(dif.M_div_cell_done), 64'd0);
      @(negedge clk);
    end
    check("done_at_latency", 64'(dif.M_div_cell_done), 64'd1);
    check("done_cycle", 64'(cyc), 64'(c0 + LAT));
    @(negedge clk);
    check("done_one_cycle", 64'(dif.M_div_cell_done), 64'd0);
    check("held_quot", 64'(dif.M_div_cell_quot), 64'(last_quot));

    // signed/unsigned and corner cases
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(32'd1234, 32'd0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);

    // kill mid-operation, then restart
    c0 = cyc;
    start_untracked(32'd999, 32'd10);
    repeat (9) @(negedge clk);
    dif.M_kill = 1'b1;
    @(negedge clk);
    dif.M_kill = 1'b0;
    check("kill_cycle", 64'(cyc), 64'(c0 + 11));
    check("kill_busy", 64'(dif.M_div_cell_busy), 64'd0);
    check("kill_state_idle", 64'(dif.dbg_state), 64'd0);
    check("kill_hold_quot", 64'(dif.M_div_cell_quot), 64'(last_quot));
    check("kill_hold_rem", 64'(dif.M_div_cell_rem), 64'(last_rem));
    @(negedge clk);
    run_op(32'd100, 32'd7, 1'b0);

    // start while busy is ignored
    issue(32'd5000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    dif.E_src1 = 32'd77; dif.E_src2 = 32'd5; dif.E_div_start = 1'b1;
    @(negedge clk);
    dif.E_div_start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // back-to-back: second start in the DONE cycle
    issue(32'hDEAD_BEEF, 32'd13, 1'b0);
    wait_done();
    issue(32'h8000_0001, 32'd3, 1'b1);
    wait_done();
    @(negedge clk);

    // random operations with random gaps (gap 0 issues in the DONE cycle)
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom() >> $urandom_range(0, 24);
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // reset mid-operation clears the output registers
    run_op(32'd50, 32'd6, 1'b0);
    start_untracked(32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(dif.M_div_cell_busy), 64'd0);
    check("midreset_quot", 64'(dif.M_div_cell_quot), 64'd0);
    check("midreset_rem", 64'(dif.M_div_cell_rem), 64'd0);
    repeat (40) @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
